// File: rtl/fifo_lane_pkg.sv
// +----------------------------------------------------------------------------+
// | fifo_lane_pkg : shared data width, pointer-width helper and reset values   |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package fifo_lane_pkg;

  localparam int DATA_W_DEF = 8;

  localparam logic DATA_RST_BIT = 1'b0;
  localparam logic FLAG_RST     = 1'b0;
  localparam logic EMPTY_RST    = 1'b1;

  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_lane_mem.sv
// +----------------------------------------------------------------------------+
// | fifo_lane_mem : DEPTH x DATA_W register file, sync write / async read      |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module fifo_lane_mem
  import fifo_lane_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  // No reset on the array: contents are only observable through valid pops.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/fifo_lane.sv
// +----------------------------------------------------------------------------+
// | fifo_lane : per-lane byte FIFO behind the demux; error flags gated by      |
// |             FIFO_LANE_ERR_EN.                       Revision : 1.0         |
// +----------------------------------------------------------------------------+
`default_nettype none

module fifo_lane
  import fifo_lane_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = 3,
  parameter int AE_THRESH = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         in0,
  input  logic                      in0_valid,
  input  logic                      pop,
  output logic [DATA_W-1:0]         out0,
  output logic                      valid_out0,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [ptr_w(DEPTH):0]     fifo_count,
  output logic                      err_overflow,
  output logic                      err_underflow
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] rd_data;
  logic              push_ok;
  logic              pop_ok;

  // When full, a concurrent pop frees the slot being written.
  always_comb begin
    push_ok = in0_valid && (!full || pop);
    pop_ok  = pop && !empty;
  end

  fifo_lane_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (in0),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      out0       <= {DATA_W{DATA_RST_BIT}};
      valid_out0 <= FLAG_RST;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        out0   <= rd_data;
      end
      valid_out0 <= pop_ok;
      case ({push_ok, pop_ok})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign full         = (fifo_count == CNT_W'(DEPTH));
  assign empty        = (fifo_count == '0);
  assign almost_full  = (fifo_count >= CNT_W'(AF_THRESH));
  assign almost_empty = (fifo_count <= CNT_W'(AE_THRESH));

`ifdef FIFO_LANE_ERR_EN
  logic ovf_q;
  logic unf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= FLAG_RST;
      unf_q <= FLAG_RST;
    end else begin
      if (in0_valid && full && !pop) begin
        ovf_q <= 1'b1;
      end
      if (pop && empty) begin
        unf_q <= 1'b1;
      end
    end
  end

  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;
`else
  assign err_overflow  = FLAG_RST;
  assign err_underflow = FLAG_RST;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_lane.sv
// +----------------------------------------------------------------------------+
// | tb_fifo_lane : scoreboard bench for fifo_lane                              |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fifo_lane;

  localparam int DEPTH = 4;
`ifdef FIFO_LANE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in0 = 8'h00;
  logic       in0_valid = 1'b0;
  logic       pop = 1'b0;
  logic [7:0] out0;
  logic       valid_out0;
  logic       full, empty, almost_full, almost_empty;
  logic [2:0] fifo_count;
  logic       err_overflow, err_underflow;

  fifo_lane dut (
    .clk           (clk),
    .reset         (reset),
    .in0           (in0),
    .in0_valid     (in0_valid),
    .pop           (pop),
    .out0          (out0),
    .valid_out0    (valid_out0),
    .full          (full),
    .empty         (empty),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .fifo_count    (fifo_count),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] mdl [$];
  logic [7:0] sb  [$];
  logic       exp_valid = 1'b0;
  logic [7:0] exp_hold  = 8'h00;
  logic       exp_ovf   = 1'b0;
  logic       exp_unf   = 1'b0;
  bit         mon_en    = 1'b0;

  // One clock: drive inputs, advance the model, return 1 ns after the edge.
  task automatic step(input logic r, input logic v, input logic [7:0] d, input logic p);
    logic full_m, empty_m, push_m, pop_m;
    reset = r; in0_valid = v; in0 = d; pop = p;
    @(posedge clk);
    full_m  = (mdl.size() == DEPTH);
    empty_m = (mdl.size() == 0);
    push_m  = v && (!full_m || p);
    pop_m   = p && !empty_m;
    if (r) begin
      mdl.delete();
      exp_valid = 1'b0;
      exp_hold  = 8'h00;
      exp_ovf   = 1'b0;
      exp_unf   = 1'b0;
    end else begin
      exp_valid = pop_m;
      if (pop_m) begin
        exp_hold = mdl.pop_front();
        sb.push_back(exp_hold);
      end
      if (push_m) mdl.push_back(d);
      if (ERR_EN && v && full_m && !p) exp_ovf = 1'b1;
      if (ERR_EN && p && empty_m)      exp_unf = 1'b1;
    end
    #1;
    reset = 1'b0; in0_valid = 1'b0; pop = 1'b0;
  endtask

  // Scoreboard side: every strobe must match the oldest expected byte.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (valid_out0 !== exp_valid) begin
        errors++;
        $display("FAIL valid_out0 got %b exp %b at %0t", valid_out0, exp_valid, $time);
      end
      if (valid_out0 === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL out0 unexpected strobe got %h exp none", out0);
        end else begin
          logic [7:0] e;
          e = sb.pop_front();
          if (out0 !== e) begin
            errors++;
            $display("FAIL out0 data got %h exp %h", out0, e);
          end
        end
      end else begin
        checks++;
        if (out0 !== exp_hold) begin
          errors++;
          $display("FAIL out0 hold got %h exp %h", out0, exp_hold);
        end
      end
    end
  end

  task automatic test_reset;
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    mon_en = 1'b1;
    checks++;
    if ({out0, valid_out0, fifo_count} !== {8'h00, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reset_data got out0=%h v=%b cnt=%0d exp 00 0 0", out0, valid_out0, fifo_count);
    end
    checks++;
    if ({empty, almost_empty, full, almost_full, err_overflow, err_underflow} !== 6'b110000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 110000",
               {empty, almost_empty, full, almost_full, err_overflow, err_underflow});
    end
  endtask

  task automatic test_basic;
    step(1'b0, 1'b1, 8'hA1, 1'b0);
    checks++;
    if ({fifo_count, empty, almost_empty} !== {3'd1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL basic_one got cnt=%0d e=%b ae=%b exp 1 0 1", fifo_count, empty, almost_empty);
    end
    step(1'b0, 1'b1, 8'hB2, 1'b0);
    step(1'b0, 1'b1, 8'hC3, 1'b0);
    checks++;
    if ({fifo_count, almost_full, empty, almost_empty, full} !== {3'd3, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_three got cnt=%0d af=%b e=%b ae=%b f=%b exp 3 1 0 0 0",
               fifo_count, almost_full, empty, almost_empty, full);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    checks++;
    if ({empty, fifo_count, sb.size() == 0} !== {1'b1, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL basic_drain got e=%b cnt=%0d pend=%0d exp 1 0 0", empty, fifo_count, sb.size());
    end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h10 + 8'(i), 1'b0);
    checks++;
    if ({full, fifo_count} !== {1'b1, 3'd4}) begin
      errors++;
      $display("FAIL ovf_fill got f=%b cnt=%0d exp 1 4", full, fifo_count);
    end
    step(1'b0, 1'b1, 8'h99, 1'b0);
    checks++;
    if ({fifo_count, err_overflow, err_underflow} !== {3'd4, exp_ovf, 1'b0}) begin
      errors++;
      $display("FAIL ovf_flag got cnt=%0d ovf=%b unf=%b exp 4 %b 0", fifo_count, err_overflow, err_underflow, exp_ovf);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    checks++;
    if ({empty, sb.size() == 0, err_overflow} !== {1'b1, 1'b1, exp_ovf}) begin
      errors++;
      $display("FAIL ovf_drain got e=%b pend=%0d ovf=%b exp 1 0 %b", empty, sb.size(), err_overflow, exp_ovf);
    end
  endtask

  task automatic test_full_push_pop;
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h10 + 8'(i), 1'b0);
    step(1'b0, 1'b1, 8'h55, 1'b1);
    checks++;
    if ({fifo_count, full, err_overflow} !== {3'd4, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL full_pp got cnt=%0d f=%b ovf=%b exp 4 1 0", fifo_count, full, err_overflow);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    checks++;
    if ({empty, sb.size() == 0, out0} !== {1'b1, 1'b1, 8'h55}) begin
      errors++;
      $display("FAIL full_pp_last got e=%b pend=%0d out0=%h exp 1 0 55", empty, sb.size(), out0);
    end
  endtask

  task automatic test_empty_push_pop;
    step(1'b0, 1'b1, 8'h77, 1'b1);
    checks++;
    if ({valid_out0, fifo_count, empty} !== {1'b0, 3'd1, 1'b0}) begin
      errors++;
      $display("FAIL empty_pp got v=%b cnt=%0d e=%b exp 0 1 0", valid_out0, fifo_count, empty);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if ({valid_out0, out0, fifo_count} !== {1'b1, 8'h77, 3'd0}) begin
      errors++;
      $display("FAIL empty_pp_pop got v=%b out0=%h cnt=%0d exp 1 77 0", valid_out0, out0, fifo_count);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_underflow;
    step(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if ({valid_out0, err_underflow, err_overflow, fifo_count} !== {1'b0, exp_unf, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL unf got v=%b unf=%b ovf=%b cnt=%0d exp 0 %b 0 0",
               valid_out0, err_underflow, err_overflow, fifo_count, exp_unf);
    end
  endtask

  task automatic test_wrap_reset;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'h30 + 8'(i), (i % 2) == 1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if ({fifo_count, err_underflow} !== {3'd2, exp_unf}) begin
      errors++;
      $display("FAIL wrap_hold got cnt=%0d unf=%b exp 2 %b", fifo_count, err_underflow, exp_unf);
    end
    step(1'b1, 1'b1, 8'hEE, 1'b1);
    checks++;
    if ({fifo_count, empty, almost_empty, valid_out0, err_overflow, err_underflow} !== {3'd0, 5'b11000}) begin
      errors++;
      $display("FAIL wrap_reset got cnt=%0d e=%b ae=%b v=%b ovf=%b unf=%b exp 0 1 1 0 0 0",
               fifo_count, empty, almost_empty, valid_out0, err_overflow, err_underflow);
    end
    step(1'b0, 1'b1, 8'hE5, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if ({out0, valid_out0, empty} !== {8'hE5, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL wrap_new got out0=%h v=%b e=%b exp e5 1 1", out0, valid_out0, empty);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_pending got %0d exp 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_underflow();
    test_wrap_reset();
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
